// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the multi-cycle ALU.
package alu_pkg;

    // 5-bit opcodes; the original 4-bit ALU codes appear zero-extended.
    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00010;
    localparam logic [4:0] OP_AND   = 5'b00100;
    localparam logic [4:0] OP_OR    = 5'b00101;
    localparam logic [4:0] OP_NOR   = 5'b00110;
    localparam logic [4:0] OP_XOR   = 5'b00111;
    localparam logic [4:0] OP_SLT   = 5'b01000;
    localparam logic [4:0] OP_SLTU  = 5'b01001;
    localparam logic [4:0] OP_SLL   = 5'b01010;
    localparam logic [4:0] OP_SRL   = 5'b01011;
    localparam logic [4:0] OP_SRA   = 5'b01100;
    localparam logic [4:0] OP_MULT  = 5'b10000;
    localparam logic [4:0] OP_MULTU = 5'b10001;
    localparam logic [4:0] OP_DIV   = 5'b10010;
    localparam logic [4:0] OP_DIVU  = 5'b10011;
    localparam logic [4:0] OP_MFHI  = 5'b10100;
    localparam logic [4:0] OP_MFLO  = 5'b10101;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        MULDIV  = 2'd1,
        CONCLUI = 2'd2
    } estado_t;

    // MULT, MULTU, DIV and DIVU occupy codes 100xx.
    function automatic logic eh_muldiv(input logic [4:0] op);
        return (op[4:2] == 3'b100);
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply (shift-add) / divide (restoring) engine.
// Works on magnitudes; the sign fix-up is applied on the final iteration edge
// together with the HI/LO write.
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               com_sinal,
    input  logic               divisao,
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    output logic               ultimo,
    output logic               done,
    output logic [LARGURA-1:0] hi,
    output logic [LARGURA-1:0] lo
);

    localparam int CW = $clog2(LARGURA) + 1;

    logic               busy_q;
    logic [CW-1:0]      cnt_q;
    logic               div_q;
    logic               neg_q;
    logic               neg_rem_q;
    logic               dz_q;
    logic [LARGURA-1:0] a_q;
    logic [LARGURA-1:0] opb_q;
    logic [LARGURA-1:0] acc_q;
    logic [LARGURA-1:0] low_q;
    logic [LARGURA-1:0] hi_q;
    logic [LARGURA-1:0] lo_q;
    logic               done_q;

    logic [LARGURA-1:0]   a_mag;
    logic [LARGURA-1:0]   b_mag;
    logic [LARGURA-1:0]   acc_d;
    logic [LARGURA-1:0]   low_d;
    logic [LARGURA-1:0]   hi_d;
    logic [LARGURA-1:0]   lo_d;
    logic [LARGURA:0]     soma;
    logic [LARGURA:0]     desl;
    logic [LARGURA:0]     dif;
    logic [2*LARGURA-1:0] prod;

    assign a_mag  = (com_sinal && a[LARGURA-1]) ? -a : a;
    assign b_mag  = (com_sinal && b[LARGURA-1]) ? -b : b;
    assign ultimo = busy_q && (cnt_q == CW'(1));
    assign done   = done_q;
    assign hi     = hi_q;
    assign lo     = lo_q;

    // One iteration of the active operation plus the signed/zero-divisor fix-up
    always_comb begin
        acc_d = acc_q;
        low_d = low_q;
        soma  = '0;
        desl  = '0;
        dif   = '0;
        prod  = '0;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (div_q) begin
            // Shift the next dividend bit into the partial remainder and try to subtract.
            desl = {acc_q, low_q[LARGURA-1]};
            dif  = desl - {1'b0, opb_q};
            if (!dif[LARGURA]) begin
                acc_d = dif[LARGURA-1:0];
                low_d = {low_q[LARGURA-2:0], 1'b1};
            end else begin
                acc_d = desl[LARGURA-1:0];
                low_d = {low_q[LARGURA-2:0], 1'b0};
            end
            if (dz_q) begin
                lo_d = '1;
                hi_d = a_q;
            end else begin
                lo_d = neg_q     ? -low_d : low_d;
                hi_d = neg_rem_q ? -acc_d : acc_d;
            end
        end else begin
            // Add the multiplicand when the multiplier LSB is set, then shift right.
            soma  = {1'b0, acc_q} + (low_q[0] ? {1'b0, opb_q} : '0);
            acc_d = soma[LARGURA:1];
            low_d = {soma[0], low_q[LARGURA-1:1]};
            prod  = {acc_d, low_d};
            if (neg_q) begin
                prod = -prod;
            end
            hi_d = prod[2*LARGURA-1:LARGURA];
            lo_d = prod[LARGURA-1:0];
        end
    end

    // Operand capture on start, iteration while busy, HI/LO write on the last step
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            a_q       <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            low_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= ultimo;
            if (start && !busy_q) begin
                busy_q    <= 1'b1;
                cnt_q     <= CW'(LARGURA);
                div_q     <= divisao;
                neg_q     <= com_sinal && (a[LARGURA-1] ^ b[LARGURA-1]);
                neg_rem_q <= com_sinal && a[LARGURA-1];
                dz_q      <= divisao && (b == '0);
                a_q       <= a;
                opb_q     <= b_mag;
                acc_q     <= '0;
                low_q     <= a_mag;
            end else if (busy_q) begin
                acc_q <= acc_d;
                low_q <= low_d;
                cnt_q <= cnt_q - CW'(1);
                if (ultimo) begin
                    busy_q <= 1'b0;
                    hi_q   <= hi_d;
                    lo_q   <= lo_d;
                end
            end
        end
    end

endmodule

// File: rtl/alu_multiciclo.sv
// Execute-stage ALU: single-cycle logic/arithmetic/shift ops plus iterative
// MULT/DIV with HI/LO behind an inicio/ocupado/pronto handshake.
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inicio,
    input  logic [4:0]         controle,
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    output logic [LARGURA-1:0] saida,
    output logic               zero,
    output logic               overflow,
    output logic [LARGURA-1:0] hi,
    output logic [LARGURA-1:0] lo,
    output logic               ocupado,
    output logic               pronto
);

    localparam int SH = $clog2(LARGURA);
    localparam int M  = LARGURA - 1;

    estado_t estado_q;
    estado_t estado_d;

    logic [LARGURA-1:0] saida_q;
    logic               zero_q;
    logic               ovf_q;
    logic               pronto_sc_q;

    logic               emite;
    logic               op_md;
    logic               seq_ultimo;
    logic               seq_done;
    logic [LARGURA-1:0] hi_w;
    logic [LARGURA-1:0] lo_w;
    logic [LARGURA-1:0] res_d;
    logic               ovf_d;
    logic [LARGURA-1:0] soma;
    logic [LARGURA-1:0] dif;
    logic [SH-1:0]      shamt;

    assign op_md = eh_muldiv(controle);
    assign emite = inicio && (estado_q == OCIOSO);
    assign soma  = a + b;
    assign dif   = a - b;
    assign shamt = b[SH-1:0];

    muldiv_seq #(
        .LARGURA (LARGURA)
    ) u_seq (
        .clock     (clock),
        .reset     (reset),
        .start     (emite && op_md),
        .com_sinal (!controle[0]),
        .divisao   (controle[1]),
        .a         (a),
        .b         (b),
        .ultimo    (seq_ultimo),
        .done      (seq_done),
        .hi        (hi_w),
        .lo        (lo_w)
    );

    // Single-cycle result and signed overflow for the current opcode
    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        case (controle)
            OP_ADD: begin
                res_d = soma;
                ovf_d = (a[M] == b[M]) && (soma[M] != a[M]);
            end
            OP_SUB: begin
                res_d = dif;
                ovf_d = (a[M] != b[M]) && (dif[M] != a[M]);
            end
            OP_AND:  res_d = a & b;
            OP_OR:   res_d = a | b;
            OP_NOR:  res_d = ~(a | b);
            OP_XOR:  res_d = a ^ b;
            OP_SLT:  res_d = {{(LARGURA-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: res_d = {{(LARGURA-1){1'b0}}, (a < b)};
            OP_SLL:  res_d = a << shamt;
            OP_SRL:  res_d = a >> shamt;
            OP_SRA:  res_d = $signed(a) >>> shamt;
            OP_MFHI: res_d = hi_w;
            OP_MFLO: res_d = lo_w;
            default: res_d = '0;
        endcase
    end

    // FSM next state: only MULT/DIV leave OCIOSO
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO:  if (emite && op_md) estado_d = MULDIV;
            MULDIV:  if (seq_ultimo) estado_d = CONCLUI;
            CONCLUI: estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Output registers for single-cycle ops; MULT/DIV leave them untouched
    always_ff @(posedge clock) begin
        if (reset) begin
            saida_q     <= '0;
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
            pronto_sc_q <= 1'b0;
        end else begin
            pronto_sc_q <= emite && !op_md;
            if (emite && !op_md) begin
                saida_q <= res_d;
                zero_q  <= (res_d == '0);
                ovf_q   <= ovf_d;
            end
        end
    end

    assign saida    = saida_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
    assign hi       = hi_w;
    assign lo       = lo_w;
    assign ocupado  = (estado_q != OCIOSO);
    assign pronto   = pronto_sc_q | seq_done;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo (LARGURA = 32).
module tb_alu_multiciclo;
    import alu_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        inicio;
    logic [4:0]  controle;
    logic [31:0] a, b;
    logic [31:0] saida, hi, lo;
    logic        zero, overflow, ocupado, pronto;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [31:0] exp_saida;
    logic        exp_zero, exp_ovf;
    logic [31:0] m_hi, m_lo;

    alu_multiciclo #(.LARGURA(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .inicio   (inicio),
        .controle (controle),
        .a        (a),
        .b        (b),
        .saida    (saida),
        .zero     (zero),
        .overflow (overflow),
        .hi       (hi),
        .lo       (lo),
        .ocupado  (ocupado),
        .pronto   (pronto)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       nome;
        logic [4:0]  op;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] es;
        logic        eo;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    // Reference for single-cycle ops, written from the arithmetic rules
    task automatic model_single(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic o);
        longint sx, sy, t;
        int     sh;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = int'(y % 32);
        r = 32'h0;
        o = 1'b0;
        case (op)
            OP_ADD:  begin t = sx + sy; r = x + y; o = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            OP_SUB:  begin t = sx - sy; r = x - y; o = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_NOR:  r = ~(x | y);
            OP_XOR:  r = x ^ y;
            OP_SLT:  r = (sx < sy) ? 32'd1 : 32'd0;
            OP_SLTU: r = (x < y) ? 32'd1 : 32'd0;
            OP_SLL:  r = x << sh;
            OP_SRL:  r = x >> sh;
            OP_SRA:  r = 32'($signed(x) >>> sh);
            OP_MFHI: r = m_hi;
            OP_MFLO: r = m_lo;
            default: r = 32'h0;
        endcase
    endtask

    task automatic model_muldiv(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] rh, output logic [31:0] rl);
        longint      sx, sy, q, rr;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        rh = 32'h0;
        rl = 32'h0;
        case (op)
            OP_MULT:  begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
            OP_MULTU: begin p = {32'h0, x} * {32'h0, y}; rh = p[63:32]; rl = p[31:0]; end
            OP_DIV: begin
                if (y == 0) begin rl = 32'hFFFFFFFF; rh = x; end
                else begin q = sx / sy; rr = sx % sy; rl = q[31:0]; rh = rr[31:0]; end
            end
            default: begin
                if (y == 0) begin rl = 32'hFFFFFFFF; rh = x; end
                else begin rl = x / y; rh = x % y; end
            end
        endcase
    endtask

    task automatic do_single(input string nm, input logic [4:0] op, input logic [31:0] va,
                             input logic [31:0] vb, input logic [31:0] es, input logic eo);
        @(negedge clock);
        inicio = 1'b1; controle = op; a = va; b = vb;
        @(posedge clock);
        #1;
        inicio = 1'b0;
        $display("op %-10s ctl=%b a=%h b=%h -> saida=%h zero=%b ovf=%b", nm, op, va, vb, saida, zero, overflow);
        chk({nm, ".saida"}, 64'(saida), 64'(es));
        chk({nm, ".zero"}, 64'(zero), 64'(es == 32'h0));
        chk({nm, ".overflow"}, 64'(overflow), 64'(eo));
        chk({nm, ".pronto"}, 64'(pronto), 64'd1);
        chk({nm, ".ocupado"}, 64'(ocupado), 64'd0);
        exp_saida = es; exp_zero = (es == 32'h0); exp_ovf = eo;
    endtask

    // Issues MULT/DIV, optionally pokes an ADD at busy cycle 'poke', checks latency and HI/LO.
    task automatic do_muldiv(input string nm, input logic [4:0] op, input logic [31:0] va,
                             input logic [31:0] vb, input logic [31:0] eh, input logic [31:0] el,
                             input int poke);
        int k;
        int ocup_err;
        ocup_err = 0;
        @(negedge clock);
        inicio = 1'b1; controle = op; a = va; b = vb;
        @(posedge clock);
        #1;
        inicio = 1'b0;
        for (k = 1; k <= 100; k++) begin
            if (pronto === 1'b1) break;
            if (ocupado !== 1'b1) ocup_err++;
            if (k == poke) begin
                inicio = 1'b1; controle = OP_ADD; a = 32'd1; b = 32'd1;
            end
            @(posedge clock);
            #1;
            inicio = 1'b0;
        end
        $display("op %-10s ctl=%b a=%h b=%h -> hi=%h lo=%h latency=%0d", nm, op, va, vb, hi, lo, k);
        chk({nm, ".latency"}, 64'(k), 64'd33);
        chk({nm, ".ocupado_hold"}, 64'(ocup_err), 64'd0);
        chk({nm, ".hi"}, 64'(hi), 64'(eh));
        chk({nm, ".lo"}, 64'(lo), 64'(el));
        chk({nm, ".ocupado_conclui"}, 64'(ocupado), 64'd1);
        chk({nm, ".saida_kept"}, {31'h0, exp_zero, exp_saida}, {31'h0, zero, saida});
        chk({nm, ".ovf_kept"}, 64'(overflow), 64'(exp_ovf));
        @(posedge clock);
        #1;
        chk({nm, ".pronto_once"}, 64'(pronto), 64'd0);
        chk({nm, ".ocupado_end"}, 64'(ocupado), 64'd0);
        m_hi = eh; m_lo = el;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] c [5];
        c[0] = 32'h0; c[1] = 32'h1; c[2] = 32'hFFFFFFFF; c[3] = 32'h80000000; c[4] = 32'h7FFFFFFF;
        if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    vec_t tab [15];

    initial begin
        logic [31:0] rs, rh, rl, ra, rb;
        logic        ro;
        logic [4:0]  rop;
        int          np;

        tab[0]  = '{"ADD_ovf",  OP_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1};
        tab[1]  = '{"SUB_zero", OP_SUB,  32'h5,        32'h5,        32'h0,        1'b0};
        tab[2]  = '{"SLT",      OP_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        1'b0};
        tab[3]  = '{"SLTU",     OP_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0};
        tab[4]  = '{"SRA",      OP_SRA,  32'h80000000, 32'h4,        32'hF8000000, 1'b0};
        tab[5]  = '{"SLL_b33",  OP_SLL,  32'h1,        32'd33,       32'h2,        1'b0};
        tab[6]  = '{"SUB_ovf",  OP_SUB,  32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1};
        tab[7]  = '{"AND",      OP_AND,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0};
        tab[8]  = '{"OR",       OP_OR,   32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0};
        tab[9]  = '{"NOR",      OP_NOR,  32'h0,        32'h0,        32'hFFFFFFFF, 1'b0};
        tab[10] = '{"XOR",      OP_XOR,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0};
        tab[11] = '{"SRL",      OP_SRL,  32'h80000000, 32'd31,       32'h1,        1'b0};
        tab[12] = '{"ADD_wrap", OP_ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b0};
        tab[13] = '{"INVALID",  5'b11111, 32'h12345678, 32'h1,       32'h0,        1'b0};
        tab[14] = '{"SRA_b36",  OP_SRA,  32'h80000010, 32'd36,       32'hF8000001, 1'b0};

        reset = 1'b1; inicio = 1'b0; controle = 5'h0; a = 32'h0; b = 32'h0;
        m_hi = 32'h0; m_lo = 32'h0; exp_saida = 32'h0; exp_zero = 1'b1; exp_ovf = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("reset.saida", 64'(saida), 64'd0);
        chk("reset.zero", 64'(zero), 64'd1);
        chk("reset.overflow", 64'(overflow), 64'd0);
        chk("reset.hi", 64'(hi), 64'd0);
        chk("reset.lo", 64'(lo), 64'd0);
        chk("reset.ocupado", 64'(ocupado), 64'd0);
        chk("reset.pronto", 64'(pronto), 64'd0);

        for (int i = 0; i < 15; i++) begin
            do_single(tab[i].nome, tab[i].op, tab[i].va, tab[i].vb, tab[i].es, tab[i].eo);
        end

        // Multi-cycle corner cases
        do_muldiv("MULT_neg", OP_MULT,  32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 0);
        do_single("MFLO_next", OP_MFLO, 32'h0, 32'h0, 32'hFFFFFFFA, 1'b0);
        do_single("MFHI", OP_MFHI, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0);
        do_muldiv("MULTU_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
        do_muldiv("DIV_neg", OP_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        do_muldiv("DIVU_zero", OP_DIVU, 32'h7, 32'h0, 32'h7, 32'hFFFFFFFF, 0);
        do_muldiv("DIV_zero_neg", OP_DIV, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 0);
        do_muldiv("DIV_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0);
        do_single("SUB_pre", OP_SUB, 32'h9, 32'h2, 32'h7, 1'b0);
        do_muldiv("MULTU_busy_add", OP_MULTU, 32'h10, 32'h10, 32'h0, 32'h100, 5);

        // Reset at iteration 10 of a DIV
        @(negedge clock);
        inicio = 1'b1; controle = OP_DIVU; a = 32'd1000; b = 32'd7;
        @(posedge clock);
        #1;
        inicio = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        $display("op %-10s reset during DIVU -> ocupado=%b hi=%h lo=%h pronto=%b", "RESET_DIV", ocupado, hi, lo, pronto);
        chk("rstdiv.ocupado", 64'(ocupado), 64'd0);
        chk("rstdiv.hi", 64'(hi), 64'd0);
        chk("rstdiv.lo", 64'(lo), 64'd0);
        chk("rstdiv.pronto", 64'(pronto), 64'd0);
        chk("rstdiv.saida", 64'(saida), 64'd0);
        chk("rstdiv.zero", 64'(zero), 64'd1);
        np = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (pronto === 1'b1) np++;
        end
        chk("rstdiv.no_pronto", 64'(np), 64'd0);
        m_hi = 32'h0; m_lo = 32'h0; exp_saida = 32'h0; exp_zero = 1'b1; exp_ovf = 1'b0;
        do_muldiv("MULT_6x7", OP_MULT, 32'd6, 32'd7, 32'h0, 32'd42, 0);

        // Randomized ops against the reference model
        for (int i = 0; i < 120; i++) begin
            rop = 5'($urandom_range(0, 31));
            ra = pick();
            rb = pick();
            if (eh_muldiv(rop)) begin
                model_muldiv(rop, ra, rb, rh, rl);
                do_muldiv("rand_md", rop, ra, rb, rh, rl, int'($urandom_range(0, 40)));
            end else begin
                model_single(rop, ra, rb, rs, ro);
                do_single("rand_sc", rop, ra, rb, rs, ro);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

endmodule
